// File: rtl/instr_feed_fifo_pkg.sv
// Shared types and RV32I encoding constants for the instruction feed FIFO.
package instr_feed_fifo_pkg;

    typedef logic [4:0]  reg_t;
    typedef logic [31:0] data_t;

    typedef enum logic [5:0] {
        NO_INST = 6'd0,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } instruction_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ADDI x0,x0,0
    localparam data_t NOP_WORD_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        instruction_t instruction;
        reg_t         rs1;
        reg_t         rs2;
        reg_t         rd;
        data_t        imm;
    } fifo_entry_t;

endpackage

// File: rtl/rv32i_encoder.sv
// Combinational RV32I encoder: maps a decoded item to a machine word plus an error flag.
module rv32i_encoder
    import instr_feed_fifo_pkg::*;
#(
    parameter data_t NOP_WORD = NOP_WORD_DEFAULT
) (
    input  fifo_entry_t entry,
    output data_t       word,
    output logic        err
);

    function automatic data_t enc_r(logic [6:0] f7, logic [2:0] f3, reg_t rs2, reg_t rs1, reg_t rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic data_t enc_i(logic [2:0] f3, logic [6:0] op, data_t imm, reg_t rs1, reg_t rd);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic data_t enc_sh(logic [6:0] f7, logic [2:0] f3, data_t imm, reg_t rs1, reg_t rd);
        return {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
    endfunction

    function automatic data_t enc_s(logic [2:0] f3, data_t imm, reg_t rs2, reg_t rs1);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic data_t enc_b(logic [2:0] f3, data_t imm, reg_t rs2, reg_t rs1);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic data_t enc_u(logic [6:0] op, data_t imm, reg_t rd);
        return {imm[31:12], rd, op};
    endfunction

    function automatic data_t enc_j(data_t imm, reg_t rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

    // Anything outside the enumeration (including NO_INST) becomes a NOP with err set.
    always_comb begin
        word = NOP_WORD;
        err  = 1'b0;
        case (entry.instruction)
            LUI:   word = enc_u(OPC_LUI, entry.imm, entry.rd);
            AUIPC: word = enc_u(OPC_AUIPC, entry.imm, entry.rd);
            JAL:   word = enc_j(entry.imm, entry.rd);
            JALR:  word = enc_i(F3_JALR, OPC_JALR, entry.imm, entry.rs1, entry.rd);
            BEQ:   word = enc_b(F3_BEQ, entry.imm, entry.rs2, entry.rs1);
            BNE:   word = enc_b(F3_BNE, entry.imm, entry.rs2, entry.rs1);
            BLT:   word = enc_b(F3_BLT, entry.imm, entry.rs2, entry.rs1);
            BGE:   word = enc_b(F3_BGE, entry.imm, entry.rs2, entry.rs1);
            BLTU:  word = enc_b(F3_BLTU, entry.imm, entry.rs2, entry.rs1);
            BGEU:  word = enc_b(F3_BGEU, entry.imm, entry.rs2, entry.rs1);
            LB:    word = enc_i(F3_LB, OPC_LOAD, entry.imm, entry.rs1, entry.rd);
            LH:    word = enc_i(F3_LH, OPC_LOAD, entry.imm, entry.rs1, entry.rd);
            LW:    word = enc_i(F3_LW, OPC_LOAD, entry.imm, entry.rs1, entry.rd);
            LBU:   word = enc_i(F3_LBU, OPC_LOAD, entry.imm, entry.rs1, entry.rd);
            LHU:   word = enc_i(F3_LHU, OPC_LOAD, entry.imm, entry.rs1, entry.rd);
            SB:    word = enc_s(F3_SB, entry.imm, entry.rs2, entry.rs1);
            SH:    word = enc_s(F3_SH, entry.imm, entry.rs2, entry.rs1);
            SW:    word = enc_s(F3_SW, entry.imm, entry.rs2, entry.rs1);
            ADDI:  word = enc_i(F3_ADD, OPC_OP_IMM, entry.imm, entry.rs1, entry.rd);
            SLTI:  word = enc_i(F3_SLT, OPC_OP_IMM, entry.imm, entry.rs1, entry.rd);
            SLTIU: word = enc_i(F3_SLTU, OPC_OP_IMM, entry.imm, entry.rs1, entry.rd);
            XORI:  word = enc_i(F3_XOR, OPC_OP_IMM, entry.imm, entry.rs1, entry.rd);
            ORI:   word = enc_i(F3_OR, OPC_OP_IMM, entry.imm, entry.rs1, entry.rd);
            ANDI:  word = enc_i(F3_AND, OPC_OP_IMM, entry.imm, entry.rs1, entry.rd);
            SLLI:  word = enc_sh(F7_BASE, F3_SLL, entry.imm, entry.rs1, entry.rd);
            SRLI:  word = enc_sh(F7_BASE, F3_SR, entry.imm, entry.rs1, entry.rd);
            SRAI:  word = enc_sh(F7_ALT, F3_SR, entry.imm, entry.rs1, entry.rd);
            ADD:   word = enc_r(F7_BASE, F3_ADD, entry.rs2, entry.rs1, entry.rd);
            SUB:   word = enc_r(F7_ALT, F3_ADD, entry.rs2, entry.rs1, entry.rd);
            SLL:   word = enc_r(F7_BASE, F3_SLL, entry.rs2, entry.rs1, entry.rd);
            SLT:   word = enc_r(F7_BASE, F3_SLT, entry.rs2, entry.rs1, entry.rd);
            SLTU:  word = enc_r(F7_BASE, F3_SLTU, entry.rs2, entry.rs1, entry.rd);
            XOR:   word = enc_r(F7_BASE, F3_XOR, entry.rs2, entry.rs1, entry.rd);
            SRL:   word = enc_r(F7_BASE, F3_SR, entry.rs2, entry.rs1, entry.rd);
            SRA:   word = enc_r(F7_ALT, F3_SR, entry.rs2, entry.rs1, entry.rd);
            OR:    word = enc_r(F7_BASE, F3_OR, entry.rs2, entry.rs1, entry.rd);
            AND:   word = enc_r(F7_BASE, F3_AND, entry.rs2, entry.rs1, entry.rd);
            default: begin
                word = NOP_WORD;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_feed_fifo.sv
// Buffers decoded instruction items and serves encoded RV32I words to core fetches,
// one cycle after each request, with a NOP whenever the buffer is empty.
module instr_feed_fifo
    import instr_feed_fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter data_t       NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [5:0]              in_instruction,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    input  logic [4:0]              in_rd,
    input  logic [31:0]             in_imm,
    input  logic                    fetch_req,
    input  logic [31:0]             fetch_addr,
    output logic                    fetch_valid,
    output logic [31:0]             fetch_data,
    output logic [31:0]             fetch_pc,
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             nop_count,
    output logic                    enc_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fifo_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    fifo_entry_t       in_entry;
    fifo_entry_t       head;
    data_t             head_word;
    logic              head_err;
    logic              push;
    logic              pop;

    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = fetch_req && (count != '0);
    assign head     = mem[rd_ptr];

    assign in_entry = '{
        instruction: instruction_t'(in_instruction),
        rs1:         in_rs1,
        rs2:         in_rs2,
        rd:          in_rd,
        imm:         in_imm
    };

    rv32i_encoder #(
        .NOP_WORD (NOP_WORD)
    ) u_encoder (
        .entry (head),
        .word  (head_word),
        .err   (head_err)
    );

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fetch_valid <= 1'b0;
            fetch_data  <= NOP_WORD;
            fetch_pc    <= '0;
            nop_count   <= '0;
            enc_err     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // A push into an empty buffer is not bypassed to a same-cycle fetch.
            fetch_valid <= fetch_req;
            if (fetch_req) begin
                fetch_pc   <= fetch_addr;
                fetch_data <= pop ? head_word : NOP_WORD;
                if (!pop && nop_count != 16'hFFFF) begin
                    nop_count <= nop_count + 16'd1;
                end
            end
            if (pop && head_err) begin
                enc_err <= 1'b1;
            end
        end
    end

endmodule
